trigger_peak_detect: RTL and testbench
======================================

# trigger_peak_detect

Converts a per-sample detection metric (e.g. preamble autocorrelation magnitude) into the one-for-one trigger stream consumed by periodic_framer. Marks exactly one sample per detection event with tlast: the first maximum within a WINDOW-sample search window opened by a threshold crossing. Output is the metric delayed by exactly WINDOW samples. The data stream feeding the framer must be delayed by the same WINDOW samples to stay aligned.

## Interface
- WINDOW, 16: search window and pipeline depth in samples; legal 2..64.
- BASE, 0: settings base address; threshold at BASE, holdoff at BASE+1.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- clear  in  1  synchronous flush; same effect as reset except settings registers keep their values.
- set_stb, set_addr, set_data  in  1/8/32  settings bus. Threshold is 32 bits, reset value 0xFFFFFFFF. Holdoff is set_data[15:0], reset value 0.
- in_tdata  in  32  unsigned metric.
- in_tlast  in  1  ignored.
- in_tvalid  in  1  metric valid.
- in_tready  out  1  metric accepted.
- out_tdata  out  32  delayed metric.
- out_tlast  out  1  peak marker (trigger).
- out_tvalid  out  1  output valid.
- out_tready  in  1  downstream ready.

## Operation
- Pipeline: WINDOW stages, each holding a 32-bit metric and a 1-bit mark. Stage 0 is the newest sample; stage WINDOW-1 is the output stage. A fill counter tracks occupancy and sets `full` once WINDOW samples have been loaded.
- Handshake (combinational):
  - in_tready = ~full | out_tready
  - accept = in_tvalid & in_tready
  - out_tvalid = full & in_tvalid
- Output pops only on the same cycle an input is accepted, so input and output stay in strict lockstep (1 in, 1 out) once full.
- On accept, all stages shift by one and the new sample enters stage 0 with mark=0.
- out_tdata and out_tlast come from stage WINDOW-1.
- FSM advances only on accept. States:
  - IDLE: if metric > threshold (strict, unsigned), go to SEARCH with peak_val=metric, age=0, cnt=1.
  - SEARCH: cnt increments. If metric > peak_val (strict, so ties keep the earliest sample), set peak_val=metric and age=0; otherwise age increments. When the updated cnt equals WINDOW, set the mark of stage `age` in the same shift, then go to HOLDOFF, or to IDLE if holdoff==0.
  - HOLDOFF: ignores the threshold. hcnt counts accepted samples; after `holdoff` samples it returns to IDLE. The first sample evaluated against the threshold is the one after the holdoff-th.
- age ≤ WINDOW-1, so the marked sample is always still in the pipeline. Exactly one mark is set per detection.
- Settings changes apply from the next cycle. A change during SEARCH or HOLDOFF does not abort the event; the new holdoff value is sampled on entry to HOLDOFF.
- The sequence of marked samples is independent of backpressure timing.

## Timing
- Reset/clear (one cycle): FSM=IDLE, fill=0, all marks=0, all stage data=0, counters=0.
- Output values after reset/clear: out_tvalid=0, out_tlast=0, out_tdata=0, in_tready=1.
- Latency: the sample accepted as input n leaves as output n+WINDOW.
- Priming: the first WINDOW accepts produce no output. On the (WINDOW+1)-th accept, output 1 transfers on the same cycle.
- No state changes when accept=0.
- A reset or clear mid-event discards any pending mark.
- If in_tvalid is high but out_tready is low while full, in_tready=0 and everything holds.
- Widths: cnt and age are clog2(WINDOW+1) bits; hcnt is 16 bits.

## Test plan
- Prime and pass-through: WINDOW=16, threshold=0xFFFFFFFF, ramp 0..99 with out_tready=1 → outputs 0..83, all tlast=0, first output valid on the 17th accept.
- Single peak: threshold=100; metrics are 0 except samples 40..44 = 150,300,500,200,120 → exactly one tlast, on output sample 42 (value 500).
- Tie and late peak:
  - Window samples 40..55 with equal maxima 300 at samples 41 and 50 → tlast on 41 only.
  - Raise sample 55 (the last sample of the window) to 900 → tlast on 55, which was in stage 0 when marked.
- Holdoff: holdoff=20, two bursts above threshold starting at samples 40 and 60 → only one tlast. Repeat with the second burst starting at sample 80 → second tlast present.
- Backpressure: single-peak stimulus with random in_tvalid/out_tready (50%) → output sequence and tlast position identical to the no-backpressure run; out_tvalid never high while in_tvalid is low.
- Clear mid-search: assert clear on the cycle sample 45 is accepted → out_tvalid=0 next cycle, no tlast ever emitted for that event, re-priming takes 16 accepts, and threshold/holdoff are retained.

Source files
------------

// File: rtl/trigger_peak_detect_if.sv
// Metric/trigger stream bundle: 32-bit data with last marker and valid/ready.
interface trigger_peak_detect_if;
    logic [31:0] tdata;
    logic        tlast;
    logic        tvalid;
    logic        tready;

    modport master (output tdata, tlast, tvalid, input tready);
    modport slave  (input tdata, tlast, tvalid, output tready);
endinterface

// File: rtl/trigger_peak_detect.sv
// Delays a detection metric by WINDOW samples and flags with tlast the first
// maximum inside the search window opened by each threshold crossing.
module trigger_peak_detect #(
    parameter int         WINDOW = 16,
    parameter logic [7:0] BASE   = 8'd0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         set_stb,
    input  logic [7:0]                   set_addr,
    input  logic [31:0]                  set_data,
    trigger_peak_detect_if.slave         metric,
    trigger_peak_detect_if.master        trigger
);
    localparam int CW = $clog2(WINDOW + 1);

    typedef enum logic [1:0] {IDLE, SEARCH, HOLDOFF} state_t;

    state_t                   state;
    logic [31:0]              threshold;
    logic [15:0]              holdoff;
    logic [15:0]              hold_lat;
    logic [15:0]              hcnt;
    logic [CW-1:0]            fill;
    logic [CW-1:0]            cnt;
    logic [CW-1:0]            age;
    logic [31:0]              peak_val;
    logic [WINDOW-1:0][31:0]  data;
    logic [WINDOW-1:0]        mark;

    logic                     full;
    logic                     accept;
    logic                     beats;
    logic                     done;
    logic [CW-1:0]            cnt_nxt;
    logic [CW-1:0]            age_nxt;
    logic [WINDOW-1:0]        mark_nxt;
    logic                     unused_tlast;

    assign unused_tlast   = metric.tlast;

    assign full           = (fill == CW'(WINDOW));
    assign metric.tready  = ~full | trigger.tready;
    assign accept         = metric.tvalid & metric.tready;
    assign trigger.tvalid = full & metric.tvalid;
    assign trigger.tdata  = data[WINDOW-1];
    assign trigger.tlast  = mark[WINDOW-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            threshold <= '1;
            holdoff   <= '0;
        end else if (set_stb) begin
            if (set_addr == BASE)
                threshold <= set_data;
            if (set_addr == BASE + 8'd1)
                holdoff <= set_data[15:0];
        end
    end

    // The incoming sample lands in stage 0 after the shift, so a peak of age a
    // sits in stage a once the shift completes; the mark is applied post-shift.
    always_comb begin
        beats    = metric.tdata > peak_val;
        cnt_nxt  = cnt + 1'b1;
        age_nxt  = beats ? '0 : age + 1'b1;
        done     = (state == SEARCH) && (cnt_nxt == CW'(WINDOW));
        mark_nxt = {mark[WINDOW-2:0], 1'b0};
        for (int i = 0; i < WINDOW; i++)
            if (done && age_nxt == CW'(i))
                mark_nxt[i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= IDLE;
            fill     <= '0;
            data     <= '0;
            mark     <= '0;
            cnt      <= '0;
            age      <= '0;
            peak_val <= '0;
            hcnt     <= '0;
            hold_lat <= '0;
        end else if (accept) begin
            data <= {data[WINDOW-2:0], metric.tdata};
            mark <= mark_nxt;
            if (!full)
                fill <= fill + 1'b1;
            case (state)
                IDLE: begin
                    if (metric.tdata > threshold) begin
                        state    <= SEARCH;
                        peak_val <= metric.tdata;
                        age      <= '0;
                        cnt      <= CW'(1);
                    end
                end
                SEARCH: begin
                    cnt <= cnt_nxt;
                    age <= age_nxt;
                    if (beats)
                        peak_val <= metric.tdata;
                    if (done) begin
                        hcnt     <= '0;
                        hold_lat <= holdoff;
                        state    <= (holdoff == '0) ? IDLE : HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    hcnt <= hcnt + 16'd1;
                    if (hcnt + 16'd1 == hold_lat)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trigger_peak_detect.sv
// Directed bench for trigger_peak_detect (WINDOW=16): priming, peak marking,
// ties, holdoff, backpressure invariance and clear behaviour.
module tb_trigger_peak_detect;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;

    trigger_peak_detect_if metric_if ();
    trigger_peak_detect_if trig_if ();

    trigger_peak_detect #(.WINDOW(16), .BASE(8'd0)) dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .metric   (metric_if),
        .trigger  (trig_if)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] stim [200];
    logic [31:0] od [256];
    logic        ol [256];
    int          no, acc, first_acc, viol;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rec_reset();
        no = 0; acc = 0; first_acc = -1; viol = 0;
    endtask

    // Inputs change 2 time units after a rising edge; outputs sampled 1 unit later.
    task automatic step(input bit v, input logic [31:0] d, input bit r, input bit clr,
                        output bit took);
        metric_if.tvalid = v;
        metric_if.tdata  = d;
        metric_if.tlast  = 1'b0;
        trig_if.tready   = r;
        clear            = clr;
        #1;
        took = metric_if.tvalid && metric_if.tready;
        if (trig_if.tvalid && !metric_if.tvalid) viol++;
        if (took) acc++;
        if (trig_if.tvalid && trig_if.tready) begin
            od[no] = trig_if.tdata;
            ol[no] = trig_if.tlast;
            if (no == 0) first_acc = acc;
            no++;
        end
        @(posedge clk);
        #2;
        clear = 1'b0;
        metric_if.tvalid = 1'b0;
    endtask

    task automatic play(input int n, input bit bp);
        int k = 0;
        int cyc = 0;
        bit took;
        while (k < n && cyc < 5000) begin
            bit v = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bit r = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            step(v, stim[k], r, 1'b0, took);
            if (took) k++;
            cyc++;
        end
        chk("play_complete", k, n);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        metric_if.tvalid = 1'b0;
        trig_if.tready = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge clk);
        #2;
        set_stb = 1'b0;
    endtask

    task automatic zero_stim();
        for (int i = 0; i < 200; i++) stim[i] = '0;
    endtask

    task automatic put_burst(input int b);
        stim[b] = 150; stim[b+1] = 300; stim[b+2] = 500; stim[b+3] = 200; stim[b+4] = 120;
    endtask

    function automatic int n_last();
        int c = 0;
        for (int i = 0; i < no; i++) if (ol[i]) c++;
        return c;
    endfunction

    function automatic int last_idx(input int which);
        int c = 0;
        for (int i = 0; i < no; i++)
            if (ol[i]) begin
                if (c == which) return i;
                c++;
            end
        return -1;
    endfunction

    function automatic int data_bad();
        int c = 0;
        for (int i = 0; i < no; i++) if (od[i] !== stim[i]) c++;
        return c;
    endfunction

    initial begin
        bit took;
        metric_if.tvalid = 1'b0;
        metric_if.tdata  = '0;
        metric_if.tlast  = 1'b0;
        trig_if.tready   = 1'b0;

        // Reset state
        do_reset();
        metric_if.tvalid = 1'b1;
        trig_if.tready = 1'b0;
        #1;
        chk("rst_in_tready", metric_if.tready, 1);
        chk("rst_out_tvalid", trig_if.tvalid, 0);
        chk("rst_out_tlast", trig_if.tlast, 0);
        chk("rst_out_tdata", trig_if.tdata, 0);
        metric_if.tvalid = 1'b0;
        @(posedge clk);
        #2;

        // Prime and pass-through with default threshold
        do_reset();
        rec_reset();
        for (int i = 0; i < 200; i++) stim[i] = i;
        play(100, 1'b0);
        chk("pass_count", no, 84);
        chk("pass_first_acc", first_acc, 17);
        chk("pass_data_bad", data_bad(), 0);
        chk("pass_tlast", n_last(), 0);
        chk("pass_viol", viol, 0);

        // Full pipeline with out_tready low holds everything
        metric_if.tvalid = 1'b1; metric_if.tdata = 999; trig_if.tready = 1'b0;
        #1;
        chk("hold_in_tready", metric_if.tready, 0);
        chk("hold_out_tvalid", trig_if.tvalid, 1);
        chk("hold_out_tdata", trig_if.tdata, 84);
        @(posedge clk);
        #3;
        chk("hold_after_tdata", trig_if.tdata, 84);
        metric_if.tvalid = 1'b0;

        // Single peak
        do_reset();
        set_reg(8'd0, 100);
        rec_reset();
        zero_stim();
        put_burst(40);
        play(100, 1'b0);
        chk("peak_count", n_last(), 1);
        chk("peak_idx", last_idx(0), 42);
        chk("peak_val", od[42], 500);
        chk("peak_data_bad", data_bad(), 0);

        // Tie keeps earliest
        do_reset();
        set_reg(8'd0, 100);
        rec_reset();
        zero_stim();
        stim[40] = 150; stim[41] = 300; stim[50] = 300;
        play(100, 1'b0);
        chk("tie_count", n_last(), 1);
        chk("tie_idx", last_idx(0), 41);

        // Peak on last window sample
        do_reset();
        set_reg(8'd0, 100);
        rec_reset();
        zero_stim();
        stim[40] = 150; stim[41] = 300; stim[50] = 300; stim[55] = 900;
        play(100, 1'b0);
        chk("late_count", n_last(), 1);
        chk("late_idx", last_idx(0), 55);

        // Holdoff suppresses second burst at 60
        do_reset();
        set_reg(8'd0, 100);
        set_reg(8'd1, 20);
        rec_reset();
        zero_stim();
        put_burst(40); put_burst(60);
        play(120, 1'b0);
        chk("hold60_count", n_last(), 1);
        chk("hold60_idx", last_idx(0), 42);

        // Second burst at 80 falls after holdoff
        do_reset();
        set_reg(8'd0, 100);
        set_reg(8'd1, 20);
        rec_reset();
        zero_stim();
        put_burst(40); put_burst(80);
        play(120, 1'b0);
        chk("hold80_count", n_last(), 2);
        chk("hold80_idx0", last_idx(0), 42);
        chk("hold80_idx1", last_idx(1), 82);

        // Backpressure yields the same stream
        do_reset();
        set_reg(8'd0, 100);
        rec_reset();
        zero_stim();
        put_burst(40);
        play(100, 1'b1);
        chk("bp_count", no, 84);
        chk("bp_first_acc", first_acc, 17);
        chk("bp_data_bad", data_bad(), 0);
        chk("bp_tlast_count", n_last(), 1);
        chk("bp_tlast_idx", last_idx(0), 42);
        chk("bp_viol", viol, 0);

        // Clear mid-search; settings survive
        do_reset();
        set_reg(8'd0, 100);
        set_reg(8'd1, 20);
        rec_reset();
        zero_stim();
        put_burst(40);
        play(45, 1'b0);
        chk("clr_pre_tlast", n_last(), 0);
        step(1'b1, stim[45], 1'b1, 1'b1, took);
        metric_if.tvalid = 1'b1; metric_if.tdata = 7; trig_if.tready = 1'b1;
        #1;
        chk("clr_out_tvalid", trig_if.tvalid, 0);
        chk("clr_out_tdata", trig_if.tdata, 0);
        chk("clr_out_tlast", trig_if.tlast, 0);
        metric_if.tvalid = 1'b0;
        #1;
        rec_reset();
        zero_stim();
        put_burst(20); put_burst(40); put_burst(60);
        play(90, 1'b0);
        chk("clr_first_acc", first_acc, 17);
        chk("clr_data_bad", data_bad(), 0);
        chk("clr_tlast_count", n_last(), 2);
        chk("clr_tlast_idx0", last_idx(0), 22);
        chk("clr_tlast_idx1", last_idx(1), 62);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
